mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Unified instruction/data memory that serves the multi-cycle CPU's MemRead/MemWrite requests, one word per transaction, with a fixed, parameterised number of wait states. It sits between the multi-cycle controller's datapath (the address chosen by IorD, the write data from register B) and the instruction and data registers. It reports completion with a one-cycle MemReady pulse and flags illegal accesses.

Parameters:
DATA_WIDTH, 32, width of a memory word and of the data ports
DEPTH_WORDS, 256, number of words stored; must be a power of two, 2 or more
WAIT_CYCLES, 2, wait states between accepting a request and completing it (0 or more)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
MemRead  input  1  read request level
MemWrite  input  1  write request level
Address  input  32  byte address; bits [1:0] must be 0
WriteData  input  DATA_WIDTH  data for a write; sampled when the request is accepted
ReadData  output  DATA_WIDTH  registered read result
MemReady  output  1  one-cycle pulse when a transaction completes
MemBusy  output  1  high while a transaction is in flight (WAIT or DONE)
AddrError  output  1  one-cycle pulse, concurrent with MemReady, for an illegal access

Behaviour:
- Reset (reset=0, takes effect immediately): state=IDLE, wait counter=0, ReadData=0, MemReady=0, MemBusy=0, AddrError=0, latched request cleared. Memory contents are not cleared. A transaction in flight when reset asserts is abandoned, and a pending write is not committed.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On a rising edge with MemRead or MemWrite set, latch Address, WriteData and the request type; this is acceptance.
  - WAIT_CYCLES=0: go to DONE. Otherwise go to WAIT with counter=WAIT_CYCLES-1.
- WAIT: on each edge, if counter==0 go to DONE, else decrement the counter.
- Commit point: the edge that enters DONE.
  - A legal write updates mem[index] at this edge.
  - A legal read loads ReadData with mem[index] at this edge.
- DONE: lasts exactly one cycle with MemReady=1 and MemBusy=1, then goes to IDLE unconditionally.
- Latency: a request accepted at edge E0 produces MemReady in the cycle following edge E0+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles after the request is presented.
- Index: index = latched Address[log2(DEPTH_WORDS)+1:2].
- Illegal access, checked on the latched request:
  - An access is illegal if Address[1:0]!=0, or Address>=4*DEPTH_WORDS, or MemRead and MemWrite were both 1.
  - An illegal access takes the same latency, then pulses AddrError with MemReady.
  - No memory write occurs, and ReadData is loaded with 0.
- ReadData holds its value until the next read (legal or illegal) completes. Writes do not change ReadData.
- Request inputs are ignored in WAIT and DONE. Inputs that change or drop after acceptance have no effect, and the transaction always completes.
- A request still asserted in the first IDLE cycle after DONE is accepted as a new transaction. The requester must deassert on MemReady to avoid a repeat access.
- MemBusy is high in WAIT and DONE, and low in IDLE.
- The CPU-side controller must hold its state until MemReady; this block adds no backpressure beyond MemBusy.
- Read-after-write to the same address returns the new data, because the write commits before the later read is accepted.

Test Plan:
1. Reset release, WAIT_CYCLES=2, MemWrite=1, Address=0x10, WriteData=0xDEADBEEF, presented for one edge E0 -> MemBusy high after E0; MemReady=1 and AddrError=0 in the cycle after E2; ReadData stays 0.
2. After test 1, MemRead=1, Address=0x10 -> ReadData=0xDEADBEEF, loaded at the edge where MemReady rises, and held after the request drops.
3. MemRead with Address=0x13, then with Address=0x400 (DEPTH_WORDS=256) -> each completes after WAIT_CYCLES+1 cycles with AddrError=1 and ReadData=0; mem[4] is unchanged.
4. MemRead=1 and MemWrite=1 together, Address=0x20, WriteData=0x1234 -> AddrError pulse; a subsequent read of 0x20 returns the prior contents.
5. Write accepted, then reset=0 asserted during WAIT, then released; then read the same address -> outputs are 0 immediately on reset; the old word is returned (the write was not committed).
6. WAIT_CYCLES=0: MemRead held high continuously at 0x0 -> MemReady pulses every 2 cycles with MemBusy alternating; a request that changes Address during DONE is ignored.

Source files
------------

// File: rtl/mem_responder.sv
// Unified instruction/data memory for the multi-cycle CPU: one word per
// transaction, fixed wait states, MemReady completion pulse and illegal-access flag.
module mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  MemReady,
    output logic                  MemBusy,
    output logic                  AddrError
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [31:0]           addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    req_t                    req_q;
    req_t                    cur;
    logic                    enter_done;
    logic                    illegal;
    logic                    commit_wr;
    logic [AW-1:0]           idx;
    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    // In IDLE the live inputs are the request; with zero wait states the
    // commit happens on the very edge that accepts it, before req_q is loaded.
    always_comb begin
        cur = req_q;
        if (state == IDLE) begin
            cur.rd   = MemRead;
            cur.wr   = MemWrite;
            cur.addr = Address;
            cur.data = WriteData;
        end
        enter_done = ((state == IDLE) && (MemRead || MemWrite) && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (cnt == '0));
        illegal    = (cur.addr[1:0] != 2'b00) ||
                     (cur.addr >= 32'(4 * DEPTH_WORDS)) ||
                     (cur.rd && cur.wr);
        idx        = cur.addr[AW+1:2];
        commit_wr  = enter_done && cur.wr && !illegal;
    end

    // Storage is never cleared; a write racing an asserted reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && commit_wr)
            mem[idx] <= cur.data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_q     <= '0;
            ReadData  <= '0;
            MemReady  <= 1'b0;
            MemBusy   <= 1'b0;
            AddrError <= 1'b0;
        end else begin
            MemReady  <= 1'b0;
            AddrError <= 1'b0;
            case (state)
                IDLE: begin
                    if (MemRead || MemWrite) begin
                        req_q   <= cur;
                        MemBusy <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) state <= DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                DONE: begin
                    state   <= IDLE;
                    MemBusy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    MemBusy <= 1'b0;
                end
            endcase
            if (enter_done) begin
                MemReady  <= 1'b1;
                AddrError <= illegal;
                if (illegal)
                    ReadData <= '0;
                else if (cur.rd)
                    ReadData <= mem[idx];
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: one responder with two wait states and one with none.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [31:0] Address = '0, WriteData = '0;
    logic [31:0] ReadData;
    logic        MemReady, MemBusy, AddrError;
    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [31:0] addr1 = '0, wdata1 = '0;
    logic [31:0] rdata1;
    logic        ready1, busy1, err1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
        .MemReady(MemReady), .MemBusy(MemBusy), .AddrError(AddrError)
    );

    mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .MemRead(rd1), .MemWrite(wr1),
        .Address(addr1), .WriteData(wdata1), .ReadData(rdata1),
        .MemReady(ready1), .MemBusy(busy1), .AddrError(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitors: pop an expectation whenever a completion is presented.
    always @(negedge clk) begin
        if (reset && MemReady) begin
            if (q0.size() == 0) begin
                chk("u0_unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("u0_latency", 32'(cyc), 32'(e.cyc));
                chk("u0_readdata", ReadData, e.rd);
                chk("u0_addrerror", {31'd0, AddrError}, {31'd0, e.err});
            end
        end
    end

    always @(negedge clk) begin
        if (reset && ready1) begin
            if (q1.size() == 0) begin
                chk("u1_unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("u1_readdata", rdata1, e.rd);
                chk("u1_addrerror", {31'd0, err1}, {31'd0, e.err});
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 20 && q0.size() > 0; i++) begin
            @(negedge clk);
            #2;
        end
        if (q0.size() != 0) begin
            chk("u0_timeout", 32'(q0.size()), 32'd0);
            q0.delete();
        end
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] erd, input logic eerr);
        exp_t e;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Address = a; WriteData = d;
        @(posedge clk);
        #1;
        chk("u0_busy_after_accept", {31'd0, MemBusy}, 32'd1);
        e.cyc = cyc + 2; e.rd = erd; e.err = eerr;
        q0.push_back(e);
        MemRead = 1'b0; MemWrite = 1'b0; Address = 32'hFFFF_FFF3; WriteData = '1;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {ReadData[27:0], MemReady, MemBusy, AddrError, 1'b0}, 32'd0);
        chk("reset_outputs_u1", {rdata1[27:0], ready1, busy1, err1, 1'b0}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: legal write, ReadData untouched
        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        // 2: read back, held after request drops
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        repeat (3) @(negedge clk);
        chk("readdata_hold", ReadData, 32'hDEADBEEF);
        chk("idle_not_busy", {31'd0, MemBusy}, 32'd0);
        // 3: misaligned and out-of-range reads, then mem[4] intact
        do_req(1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
        do_req(1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        // 4: simultaneous read+write is illegal and writes nothing
        do_req(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0);
        do_req(1'b1, 1'b1, 32'h20, 32'h1234, 32'h0, 1'b1);
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
        // 5: reset during WAIT abandons the write
        @(negedge clk);
        MemWrite = 1'b1; Address = 32'h20; WriteData = 32'h55AA;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_mid_readdata", ReadData, 32'h0);
        chk("reset_mid_flags", {29'd0, MemReady, MemBusy, AddrError}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);

        // 6: zero wait states, request held, Address disturbed during DONE
        @(negedge clk);
        wr1 = 1'b1; addr1 = 32'h0; wdata1 = 32'h1111_0000;
        e.cyc = 0; e.rd = 32'h0; e.err = 1'b0;
        q1.push_back(e);
        @(posedge clk);
        #1;
        chk("u1_write_ready", {30'd0, ready1, busy1}, 32'd3);
        wr1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rd1 = 1'b1; addr1 = 32'h0;
        for (int i = 0; i < 3; i++) begin
            e.cyc = 0; e.rd = 32'h1111_0000; e.err = 1'b0;
            q1.push_back(e);
        end
        for (int i = 0; i < 6; i++) begin
            logic exp_rdy;
            exp_rdy = ((i % 2) == 0);
            @(posedge clk);
            #1;
            chk("u1_ready_toggle", {31'd0, ready1}, {31'd0, exp_rdy});
            chk("u1_busy_toggle", {31'd0, busy1}, {31'd0, exp_rdy});
            addr1 = exp_rdy ? 32'h13 : 32'h0;
            if (i == 5) rd1 = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("u0_queue_empty", 32'(q0.size()), 32'd0);
        chk("u1_queue_empty", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
